// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/forwarding controller.
package hazard_pkg;

  // EX operand mux select encoding; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int REG_W_DEFAULT    = 5;
  localparam int MAX_WAIT_DEFAULT = 255;
  localparam int CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/forward_sel.sv
// Operand forwarding select for one EX source register.
// The younger producer (EX/MEM) takes precedence over MEM/WB; register 0 never forwards.
module forward_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_reg_write_i,
  output fwd_sel_t         sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
  assign wb_hit  = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == src_i);

  // Priority select: EX/MEM result, then WB data, then register file.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Drives only enables, flushes and mux selects. Priority: freeze > branch > load-use.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = REG_W_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             back_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;

  logic     freeze;
  logic     load_use_raw;
  logic     branch_go;
  logic     load_use;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  forward_sel #(.REG_W(REG_W)) u_fwd_a (
    .src_i          (ex_rs),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .sel_o          (sel_a)
  );

  forward_sel #(.REG_W(REG_W)) u_fwd_b (
    .src_i          (ex_rt),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .sel_o          (sel_b)
  );

  assign freeze       = mem_access & ~dmem_ready;
  assign load_use_raw = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign branch_go    = branch_taken & ~freeze;
  // A load-use alongside a taken branch belongs to the wrong path and is dropped.
  assign load_use     = load_use_raw & ~freeze & ~branch_taken;

  assign pc_en      = ~rst & ~freeze & ~load_use;
  assign ifid_en    = ~rst & ~freeze & ~load_use;
  assign back_en    = ~rst & ~freeze;
  assign ifid_flush = rst | branch_go;
  assign idex_flush = rst | branch_go | load_use;
  assign fwd_a      = rst ? FWD_RF : sel_a;
  assign fwd_b      = rst ? FWD_RF : sel_b;

  assign mem_timeout = timeout_q;

  // Memory-wait FSM with saturating watchdog; timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          wait_cnt_q <= '0;
          if (freeze) begin
            state_q <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + WAIT_ONE;
            if ((wait_cnt_q + WAIT_ONE) == WAIT_MAX) begin
              timeout_q <= 1'b1;
            end
          end
          if (dmem_ready) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] freeze_cnt_q;

  // Saturating event counters for bubbles, branch flushes and freeze cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (load_use && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (branch_go && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
      if (freeze && (freeze_cnt_q != '1)) begin
        freeze_cnt_q <= freeze_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: the driver pushes expected outputs
// from a behavioural model, a monitor pops and compares each cycle.
module tb_hazard_forward_ctrl;

  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             ex_mem_read, mem_rw, wb_rw, br, ma, dr;
  } stim_t;

  typedef struct {
    logic [3:0]  fwd;
    logic [4:0]  ctrl;
    logic        tmo;
    logic [47:0] cnts;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_access, dmem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic pc_en, ifid_en, back_en, ifid_flush, idex_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  exp_t exp_q[$];
  stim_t cur;

  // Reference model state
  bit m_waiting;
  int m_edges;
  bit m_tmo;
  int m_stall, m_flush, m_freeze;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .ifid_en(ifid_en), .back_en(back_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.id_rs = '0; s.id_rt = '0; s.ex_rs = '0; s.ex_rt = '0; s.ex_rd = '0;
    s.mem_rd = '0; s.wb_rd = '0; s.ex_mem_read = 1'b0; s.mem_rw = 1'b0; s.wb_rw = 1'b0;
    s.br = 1'b0; s.ma = 1'b0; s.dr = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] fwd_of(logic [REG_W-1:0] src, stim_t s);
    if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == src) return 2'd2;
    if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit hazard(stim_t s);
    return s.ex_mem_read && s.ex_rd != 0 && (s.ex_rd == s.id_rs || s.ex_rd == s.id_rt);
  endfunction

  function automatic int sat(int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic model_edge(stim_t p);
    bit frz;
    frz = p.ma && !p.dr;
    if (p.rst) begin
      m_waiting = 0; m_edges = 0; m_tmo = 0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      if (m_waiting) begin
        if (m_edges < MAX_WAIT) m_edges++;
        if (m_edges == MAX_WAIT) m_tmo = 1;
        if (p.dr) m_waiting = 0;
      end else begin
        m_edges = 0;
        if (frz) m_waiting = 1;
      end
      if (frz) m_freeze = sat(m_freeze);
      else if (p.br) m_flush = sat(m_flush);
      else if (hazard(p)) m_stall = sat(m_stall);
    end
  endtask

  function automatic exp_t expect_for(stim_t s);
    exp_t e;
    bit frz;
    frz = s.ma && !s.dr;
    // ctrl = {pc_en, ifid_en, back_en, ifid_flush, idex_flush}
    if (s.rst) begin
      e.fwd = 4'b0000; e.ctrl = 5'b00011;
    end else begin
      e.fwd = {fwd_of(s.ex_rs, s), fwd_of(s.ex_rt, s)};
      if (frz)            e.ctrl = 5'b00000;
      else if (s.br)      e.ctrl = 5'b11111;
      else if (hazard(s)) e.ctrl = 5'b00101;
      else                e.ctrl = 5'b11100;
    end
    e.tmo = m_tmo;
`ifdef HAZARD_STATS_EN
    e.cnts = {16'(m_stall), 16'(m_flush), 16'(m_freeze)};
`else
    e.cnts = '0;
`endif
    e.cyc = cycle;
    return e;
  endfunction

  task automatic drive(stim_t s);
    rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; ex_rs = s.ex_rs; ex_rt = s.ex_rt;
    ex_rd = s.ex_rd; mem_rd = s.mem_rd; wb_rd = s.wb_rd; ex_mem_read = s.ex_mem_read;
    mem_reg_write = s.mem_rw; wb_reg_write = s.wb_rw; branch_taken = s.br;
    mem_access = s.ma; dmem_ready = s.dr;
  endtask

  task automatic apply(stim_t s);
    @(posedge clk);
    model_edge(cur);
    #1;
    cycle++;
    cur = s;
    drive(s);
    exp_q.push_back(expect_for(s));
  endtask

  task automatic check(string name, int cyc, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("fwd", e.cyc, 64'({fwd_a, fwd_b}), 64'(e.fwd));
        check("ctrl", e.cyc, 64'({pc_en, ifid_en, back_en, ifid_flush, idex_flush}), 64'(e.ctrl));
        check("timeout", e.cyc, 64'(mem_timeout), 64'(e.tmo));
        check("counters", e.cyc, 64'({stall_cnt, flush_cnt, freeze_cnt}), 64'(e.cnts));
      end
    end
  end

  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1'b1;
    drive(cur);

    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);

    // Forwarding priority and register-0 exclusion
    s = idle(); s.mem_rd = 5; s.mem_rw = 1; s.wb_rd = 5; s.wb_rw = 1; s.ex_rs = 5; s.ex_rt = 5;
    apply(s);
    s.mem_rw = 0; apply(s);
    s.mem_rw = 1; s.mem_rd = 0; s.wb_rd = 0; s.ex_rs = 0; s.ex_rt = 0; apply(s);
    s = idle(); s.mem_rd = 3; s.mem_rw = 1; s.wb_rd = 7; s.wb_rw = 1; s.ex_rs = 7; s.ex_rt = 3;
    apply(s);

    // Load-use bubble, then normal
    s = idle(); s.ex_mem_read = 1; s.ex_rd = 8; s.id_rt = 8; apply(s);
    apply(idle());
    // Load-use with taken branch: branch wins
    s.br = 1; apply(s);
    apply(idle());

    // Freeze for 3 cycles with branch held, then release with flush
    s = idle(); s.ma = 1; s.dr = 0; s.br = 1;
    repeat (3) apply(s);
    s.dr = 1; apply(s);
    apply(idle());

    // Watchdog: held wait past MAX_WAIT, sticky after ready, cleared by reset
    s = idle(); s.ma = 1; s.dr = 0;
    repeat (7) apply(s);
    s.dr = 1; apply(s);
    apply(idle()); apply(idle());
    s = idle(); s.rst = 1; apply(s);
    apply(idle());

    // Reset mid-wait
    s = idle(); s.ma = 1; s.dr = 0; s.ex_mem_read = 1; s.ex_rd = 2; s.id_rs = 2;
    repeat (2) apply(s);
    s.rst = 1; apply(s);
    apply(idle()); apply(idle());

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.rst         = ($urandom_range(0, 63) == 0);
      s.id_rs       = 5'($urandom_range(0, 3));
      s.id_rt       = 5'($urandom_range(0, 3));
      s.ex_rs       = 5'($urandom_range(0, 3));
      s.ex_rt       = 5'($urandom_range(0, 3));
      s.ex_rd       = 5'($urandom_range(0, 3));
      s.mem_rd      = 5'($urandom_range(0, 3));
      s.wb_rd       = 5'($urandom_range(0, 3));
      s.ex_mem_read = 1'($urandom_range(0, 1));
      s.mem_rw      = 1'($urandom_range(0, 1));
      s.wb_rw       = 1'($urandom_range(0, 1));
      s.br          = ($urandom_range(0, 3) == 0);
      s.ma          = ($urandom_range(0, 2) == 0);
      s.dr          = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
